// File: rtl/clock_pkg.sv
// Shared widths and limits for the alarm clock time fields.
package clock_pkg;
  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;
  localparam int MAX_HOUR = 23;
  localparam int MAX_MIN  = 59;
  localparam int MAX_SEC  = 59;
endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with synchronous load (priority over inc) and a
// combinational carry-out asserted when an increment wraps N-1 -> 0.
module mod_counter #(
  parameter int N       = 60,
  parameter int W       = 6,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_count,
  output logic         o_carry
);
  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = (r_count == W'(N - 1));
  assign o_carry  = i_inc && w_at_max;
  assign o_count  = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= W'(RST_VAL);
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_inc) begin
      r_count <= w_at_max ? '0 : r_count + 1'b1;
    end
  end
endmodule

// File: rtl/alarm_clock_core.sv
// Time-of-day clock with prescaler, validated time load, 12h/24h display
// and a level alarm that is raised only by a counting tick.
module alarm_clock_core
  import clock_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int RESET_HOUR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode_12h,
  // Load handshake: set_valid is a one-cycle request; exactly one of
  // set_ack / set_err pulses on the following cycle in response.
  input  logic              set_valid,
  input  logic [HOUR_W-1:0] set_hour,
  input  logic [MIN_W-1:0]  set_min,
  input  logic [SEC_W-1:0]  set_sec,
  output logic              set_ack,
  output logic              set_err,
  input  logic              alm_en,
  input  logic [HOUR_W-1:0] alm_hour,
  input  logic [MIN_W-1:0]  alm_min,
  input  logic              alm_ack,
  output logic              alarm,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  minute,
  output logic [SEC_W-1:0]  second,
  output logic              pm,
  output logic              sec_tick
);
  localparam int PW = $clog2(CLK_HZ);

  logic [PW-1:0]     r_presc;
  logic              r_sec_tick;
  logic              r_set_ack;
  logic              r_set_err;
  logic              r_alarm;

  logic              w_tick;
  logic              w_set_legal;
  logic              w_set_bad;
  logic              w_adv;
  logic [SEC_W-1:0]  w_sec;
  logic [MIN_W-1:0]  w_min;
  logic [HOUR_W-1:0] w_hour;
  logic              w_sec_carry;
  logic              w_min_carry;
  logic              w_hour_carry;
  logic [MIN_W-1:0]  w_next_min;
  logic [HOUR_W-1:0] w_next_hour;
  logic              w_alm_legal;
  logic              w_match;
  logic [HOUR_W-1:0] w_disp_hour;

  assign w_tick      = en && (r_presc == PW'(CLK_HZ - 1));
  assign w_set_legal = set_valid && (set_hour <= HOUR_W'(MAX_HOUR))
                       && (set_min <= MIN_W'(MAX_MIN)) && (set_sec <= SEC_W'(MAX_SEC));
  assign w_set_bad   = set_valid && !w_set_legal;
  // A legal load overrides a coincident tick.
  assign w_adv       = w_tick && !w_set_legal;

  mod_counter #(.N(MAX_SEC + 1), .W(SEC_W), .RST_VAL(0)) u_sec (
    .clk(clk), .rst(rst), .i_inc(w_adv), .i_load(w_set_legal),
    .i_load_val(set_sec), .o_count(w_sec), .o_carry(w_sec_carry)
  );

  mod_counter #(.N(MAX_MIN + 1), .W(MIN_W), .RST_VAL(0)) u_min (
    .clk(clk), .rst(rst), .i_inc(w_sec_carry), .i_load(w_set_legal),
    .i_load_val(set_min), .o_count(w_min), .o_carry(w_min_carry)
  );

  mod_counter #(.N(MAX_HOUR + 1), .W(HOUR_W), .RST_VAL(RESET_HOUR)) u_hour (
    .clk(clk), .rst(rst), .i_inc(w_min_carry), .i_load(w_set_legal),
    .i_load_val(set_hour), .o_count(w_hour), .o_carry(w_hour_carry)
  );

  // Time produced by a second-wrap tick; only meaningful when w_sec_carry=1.
  assign w_next_min  = w_min_carry ? '0 : w_min + 1'b1;
  assign w_next_hour = w_hour_carry ? '0 : (w_min_carry ? w_hour + 1'b1 : w_hour);
  assign w_alm_legal = (alm_hour <= HOUR_W'(MAX_HOUR)) && (alm_min <= MIN_W'(MAX_MIN));
  assign w_match     = alm_en && w_alm_legal && w_sec_carry
                       && (w_next_hour == alm_hour) && (w_next_min == alm_min);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc    <= '0;
      r_sec_tick <= 1'b0;
      r_set_ack  <= 1'b0;
      r_set_err  <= 1'b0;
      r_alarm    <= 1'b0;
    end else begin
      r_sec_tick <= w_adv;
      r_set_ack  <= w_set_legal;
      r_set_err  <= w_set_bad;
      if (w_set_legal) begin
        r_presc <= '0;
      end else if (en) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
      end
      if (!alm_en) begin
        r_alarm <= 1'b0;
      end else if (w_match) begin
        r_alarm <= 1'b1;
      end else if (alm_ack) begin
        r_alarm <= 1'b0;
      end
    end
  end

  always_comb begin
    w_disp_hour = w_hour;
    if (mode_12h) begin
      if (w_hour == '0) begin
        w_disp_hour = HOUR_W'(12);
      end else if (w_hour > HOUR_W'(12)) begin
        w_disp_hour = w_hour - HOUR_W'(12);
      end
    end
  end

  assign hour     = w_disp_hour;
  assign minute   = w_min;
  assign second   = w_sec;
  assign pm       = (w_hour >= HOUR_W'(12));
  assign sec_tick = r_sec_tick;
  assign set_ack  = r_set_ack;
  assign set_err  = r_set_err;
  assign alarm    = r_alarm;
endmodule

// File: tb/tb_alarm_clock_core.sv
// Directed bench for alarm_clock_core: load table plus multi-cycle sequences.
module tb_alarm_clock_core;
  localparam int CLK_HZ = 4;
  localparam int RST_H  = 3;

  logic       clk = 1'b0;
  logic       rst, en, mode_12h, set_valid, alm_en, alm_ack;
  logic [4:0] set_hour, alm_hour;
  logic [5:0] set_min, set_sec, alm_min;
  logic       set_ack, set_err, alarm, pm, sec_tick;
  logic [4:0] hour;
  logic [5:0] minute, second;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       mode;
    int         e_ack;
    int         e_err;
    int         e_hour;
    int         e_pm;
    int         e_min;
    int         e_sec;
  } vec_t;

  vec_t vecs[13];

  alarm_clock_core #(.CLK_HZ(CLK_HZ), .RESET_HOUR(RST_H)) dut (
    .clk(clk), .rst(rst), .en(en), .mode_12h(mode_12h),
    .set_valid(set_valid), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .set_ack(set_ack), .set_err(set_err),
    .alm_en(alm_en), .alm_hour(alm_hour), .alm_min(alm_min), .alm_ack(alm_ack),
    .alarm(alarm), .hour(hour), .minute(minute), .second(second),
    .pm(pm), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: act=%0d req=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_time(input string name, input int h, input int m, input int s);
    chk({name, ".hour"}, int'(hour), h);
    chk({name, ".min"}, int'(minute), m);
    chk({name, ".sec"}, int'(second), s);
  endtask

  task automatic load(input int h, input int m, input int s);
    set_valid = 1'b1;
    set_hour  = 5'(h);
    set_min   = 6'(m);
    set_sec   = 6'(s);
    step();
    set_valid = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int tick_cnt;
    int t1, t2;

    rst = 1'b1; en = 1'b0; mode_12h = 1'b0; set_valid = 1'b0;
    set_hour = '0; set_min = '0; set_sec = '0;
    alm_en = 1'b0; alm_hour = '0; alm_min = '0; alm_ack = 1'b0;

    vecs[0]  = '{5'd10, 6'd20, 6'd30, 1'b0, 1, 0, 10, 0, 20, 30};
    vecs[1]  = '{5'd24, 6'd0,  6'd0,  1'b0, 0, 1, 10, 0, 20, 30};
    vecs[2]  = '{5'd12, 6'd60, 6'd0,  1'b0, 0, 1, 10, 0, 20, 30};
    vecs[3]  = '{5'd12, 6'd0,  6'd60, 1'b0, 0, 1, 10, 0, 20, 30};
    vecs[4]  = '{5'd31, 6'd63, 6'd63, 1'b0, 0, 1, 10, 0, 20, 30};
    vecs[5]  = '{5'd0,  6'd30, 6'd0,  1'b1, 1, 0, 12, 0, 30, 0};
    vecs[6]  = '{5'd12, 6'd0,  6'd0,  1'b1, 1, 0, 12, 1, 0,  0};
    vecs[7]  = '{5'd13, 6'd5,  6'd0,  1'b1, 1, 0, 1,  1, 5,  0};
    vecs[8]  = '{5'd0,  6'd30, 6'd0,  1'b0, 1, 0, 0,  0, 30, 0};
    vecs[9]  = '{5'd12, 6'd0,  6'd0,  1'b0, 1, 0, 12, 1, 0,  0};
    vecs[10] = '{5'd13, 6'd5,  6'd0,  1'b0, 1, 0, 13, 1, 5,  0};
    vecs[11] = '{5'd23, 6'd59, 6'd59, 1'b1, 1, 0, 11, 1, 59, 59};
    vecs[12] = '{5'd12, 6'd60, 6'd0,  1'b1, 0, 1, 11, 1, 59, 59};

    // Reset state
    steps(2);
    chk_time("reset", RST_H, 0, 0);
    chk("reset.alarm", int'(alarm), 0);
    chk("reset.tick", int'(sec_tick), 0);
    chk("reset.ack", int'(set_ack), 0);
    chk("reset.err", int'(set_err), 0);
    chk("reset.pm", int'(pm), 0);
    rst = 1'b0;
    step();

    // Load table with counting stopped
    for (int i = 0; i < 13; i++) begin
      mode_12h = vecs[i].mode;
      load(int'(vecs[i].h), int'(vecs[i].m), int'(vecs[i].s));
      chk($sformatf("vec%0d.ack", i), int'(set_ack), vecs[i].e_ack);
      chk($sformatf("vec%0d.err", i), int'(set_err), vecs[i].e_err);
      chk_time($sformatf("vec%0d", i), vecs[i].e_hour, vecs[i].e_min, vecs[i].e_sec);
      chk($sformatf("vec%0d.pm", i), int'(pm), vecs[i].e_pm);
      step();
      chk($sformatf("vec%0d.ack_pulse", i), int'(set_ack), 0);
      chk($sformatf("vec%0d.err_pulse", i), int'(set_err), 0);
    end

    // en=0: frozen for 20 cycles
    mode_12h = 1'b0;
    tick_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sec_tick) tick_cnt++;
    end
    chk("frozen.ticks", tick_cnt, 0);
    chk_time("frozen", 23, 59, 59);

    // Roll-over: 23:59:58 + 2 s
    en = 1'b1;
    load(23, 59, 58);
    chk("roll.ack", int'(set_ack), 1);
    tick_cnt = 0; t1 = -1; t2 = -1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (sec_tick) begin
        tick_cnt++;
        if (t1 < 0) t1 = i; else t2 = i;
      end
    end
    chk("roll.ticks", tick_cnt, 2);
    chk("roll.first_tick", t1, 4);
    chk("roll.second_tick", t2, 8);
    chk_time("roll", 0, 0, 0);

    // Load on the tick cycle wins and suppresses sec_tick
    steps(3);
    load(8, 0, 0);
    chk("coll.ack", int'(set_ack), 1);
    chk("coll.tick", int'(sec_tick), 0);
    chk_time("coll", 8, 0, 0);
    steps(3);
    chk("coll.pre_tick", int'(sec_tick), 0);
    step();
    chk("coll.next_tick", int'(sec_tick), 1);
    chk_time("coll.next", 8, 0, 1);

    // Alarm at 07:15
    alm_en = 1'b1; alm_hour = 5'd7; alm_min = 6'd15;
    load(7, 14, 59);
    chk("alm.load_no_alarm", int'(alarm), 0);
    steps(3);
    chk("alm.pre_match", int'(alarm), 0);
    step();
    chk("alm.tick", int'(sec_tick), 1);
    chk_time("alm.match", 7, 15, 0);
    chk("alm.set", int'(alarm), 1);
    step();
    chk("alm.hold", int'(alarm), 1);
    alm_ack = 1'b1;
    step();
    alm_ack = 1'b0;
    chk("alm.ack_clear", int'(alarm), 0);
    load(7, 15, 0);
    chk("alm.load_match", int'(alarm), 0);
    steps(4);
    chk("alm.after_load_tick", int'(alarm), 0);
    chk_time("alm.after_load", 7, 15, 1);

    // Match and ack in the same cycle: match wins
    alm_ack = 1'b1;
    load(7, 14, 59);
    steps(4);
    chk("almcoll.set", int'(alarm), 1);
    step();
    chk("almcoll.ack_clear", int'(alarm), 0);
    alm_ack = 1'b0;

    // alm_en=0 clears
    load(7, 14, 59);
    steps(4);
    chk("almen.set", int'(alarm), 1);
    alm_en = 1'b0;
    step();
    chk("almen.clear", int'(alarm), 0);
    alm_en = 1'b1;

    // Async reset while alarm=1 at 05:06:07
    alm_hour = 5'd5; alm_min = 6'd6;
    load(5, 5, 59);
    steps(4);
    chk("arst.alarm_before", int'(alarm), 1);
    en = 1'b0;
    load(5, 6, 7);
    chk("arst.alarm_kept", int'(alarm), 1);
    chk_time("arst.before", 5, 6, 7);
    chk("arst.ack_before", int'(set_ack), 1);
    #2 rst = 1'b1;
    #1;
    chk_time("arst.async", RST_H, 0, 0);
    chk("arst.alarm", int'(alarm), 0);
    chk("arst.ack", int'(set_ack), 0);
    chk("arst.pm", int'(pm), 0);
    step();
    rst = 1'b0;
    en = 1'b1;
    steps(3);
    chk("arst.resume_pre", int'(second), 0);
    step();
    chk("arst.resume_tick", int'(sec_tick), 1);
    chk_time("arst.resume", RST_H, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alarm_clock_core.md
ALARM_CLOCK_CORE -- requirements
Module: alarm_clock_core

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, clock cycles per second; legal range 2 and above.
REQ-002 SHALL have parameter RESET_HOUR, default 0, hour loaded at reset in 24h form; legal range 0..23.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 en  in  1  run enable; 1 = prescaler advances.
REQ-006 mode_12h  in  1  display mode; 1 = 12h, 0 = 24h.
REQ-007 set_valid  in  1  single-cycle time-load request.
REQ-008 set_hour / set_min / set_sec  in  5/6/6  load value, 24h form; sampled when set_valid=1.
REQ-009 set_ack / set_err  out  1/1  one-cycle load accepted / load rejected.
REQ-010 alm_en  in  1  alarm enable.
REQ-011 alm_hour / alm_min  in  5/6  alarm time, 24h form; live inputs.
REQ-012 alm_ack  in  1  alarm acknowledge.
REQ-013 alarm  out  1  alarm active, level output.
REQ-014 hour / minute / second  out  5/6/6  current time; hour is in display form.
REQ-015 pm  out  1  1 when the internal 24h hour is 12 or more, in both modes.
REQ-016 sec_tick  out  1  one-cycle pulse per elapsed second.

Function
REQ-017 Prescaler: counts 0..CLK_HZ-1 while en=1 and holds while en=0; width SHALL be $clog2(CLK_HZ).
REQ-018 Tick: when the prescaler is at CLK_HZ-1 with en=1, it SHALL wrap to 0, sec_tick SHALL go high at the next edge for one cycle, and second SHALL advance at that same edge.
REQ-019 Roll-over: second wraps 59->0 and carries into minute; minute wraps 59->0 and carries into hour; hour wraps 23->0; 23:59:59 + tick = 00:00:00 with no carry beyond hour.
REQ-020 Load, legal request: set_valid=1 with set_hour<=23, set_min<=59, set_sec<=59 SHALL at the next edge load the time, clear the prescaler to 0, and pulse set_ack for one cycle.
REQ-021 Load, illegal request: any field out of range SHALL leave all state unchanged and pulse set_err for one cycle.
REQ-022 Load is independent of en.
REQ-023 A legal load in the same cycle as a tick SHALL win; the tick is discarded and sec_tick stays 0.
REQ-024 Display: mode_12h=0 gives hour = internal hour. mode_12h=1 maps 0->12, 1..12 unchanged, 13..23 -> h-12. Combinational from state; no added latency.
REQ-025 Alarm set: on a tick that produces hh:mm:00 where hh=alm_hour, mm=alm_min and alm_en=1, alarm SHALL be 1 from the next edge.
REQ-026 A load SHALL never raise alarm.
REQ-027 alm_hour>23 or alm_min>59 SHALL never match.
REQ-028 Alarm clear: alarm holds 1 until alm_ack=1 or alm_en=0, and clears at the next edge.
REQ-029 If a new alarm match and alm_ack occur in the same cycle, the match wins and alarm stays 1.
REQ-030 If alm_en=0, alarm is 0.
REQ-031 Alarm matching SHALL use 24h values regardless of mode_12h.

Reset
REQ-032 rst=1 SHALL immediately force: prescaler=0, internal hour=RESET_HOUR, minute=0, second=0, alarm=0, sec_tick=0, set_ack=0, set_err=0.
REQ-033 A set_valid or tick coincident with rst SHALL be lost.
REQ-034 Reset asserted mid-count or mid-alarm SHALL give the same result as REQ-032.
REQ-035 Operation SHALL resume on the first rising edge after rst deasserts.

Structure
REQ-036 Package clock_pkg SHALL hold: HOUR_W=5, MIN_W=6, SEC_W=6, MAX_HOUR=23, MAX_MIN=59, MAX_SEC=59.
REQ-037 Sub-module mod_counter SHALL be a parametrised modulo-N counter with inc and load inputs and a carry-out; alarm_clock_core SHALL instantiate it three times, for seconds, minutes and hours.
REQ-038 The prescaler, load check, display mapping and alarm logic SHALL reside in the top module.

Verification
REQ-039 Roll-over: CLK_HZ=4, load 23:59:58 legal -> set_ack pulse; after 8 cycles time=00:00:00 and exactly 2 sec_tick pulses seen, each 4 cycles apart.
REQ-040 Illegal load: set_valid with 24:00:00, then 12:60:00 -> each gives set_err pulse, no set_ack, time unchanged; en=0 for 20 cycles -> no sec_tick, time frozen.
REQ-041 12h mode: load 00:30:00, 12:00:00, 13:05:00 with mode_12h=1 -> hour/pm = 12/0, 12/1, 1/1; with mode_12h=0 -> hour = 0, 12, 13.
REQ-042 Alarm: alm_en=1, alarm 07:15, load 07:14:59 -> no alarm on load; alarm=1 one cycle after next tick; alm_ack -> alarm=0; load 07:15:00 -> alarm stays 0.
REQ-043 Collisions: set_valid on the tick cycle -> loaded value kept, sec_tick=0. Alarm match with alm_ack in the same cycle -> alarm=1.
REQ-044 Async reset: assert rst between clock edges while alarm=1 and time 05:06:07 -> outputs go to reset values before the next edge; time = RESET_HOUR:00:00, and counting resumes after release.
